// File: rtl/wave_sample_packer.sv
// wave_sample_packer: packs a 16-bit sample stream into 32-bit words
// (even sample in the low half, odd sample in the high half) and queues
// them in a small first-word-fall-through FIFO. Words that arrive while
// the FIFO is full and not draining are dropped and flagged in the sticky ovf.
//
// Optional build macro: PACKER_OVF_COUNT_EN adds the ovf_count port and
// a saturating counter of dropped words.
//
// Handshake: an output word transfers on a cycle where m_valid and m_ready
// are both high. m_valid is high whenever the FIFO holds a word. m_data
// stays stable while m_valid is high and m_ready is low. The input side
// has no ready: a sample is taken on every cycle where enable and s_valid
// are both high.
module wave_sample_packer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          enable,
    input  logic                          s_valid,
    input  logic [SAMPLE_WIDTH-1:0]       s_data,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [2*SAMPLE_WIDTH-1:0]     m_data,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          phase_odd,
    output logic                          ovf,
    input  logic                          ovf_clear,
`ifdef PACKER_OVF_COUNT_EN
    output logic [COUNT_WIDTH-1:0]        ovf_count,
`endif
    output logic [COUNT_WIDTH-1:0]        word_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int WORD_W = 2 * SAMPLE_WIDTH;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    phase_t                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] low_q, low_d;
    logic                    push_req;
    logic [WORD_W-1:0]       push_word;

    logic [WORD_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [FILL_W-1:0]       count;
    logic                    full;
    logic                    pop;
    logic                    push_ok;
    logic                    drop;

    // Phase register and held low half; reset discards any pending half.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= PH_EVEN;
            low_q   <= '0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
        end
    end

    // Phase next-state and word formation; disabling forces the even phase.
    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        push_req  = 1'b0;
        push_word = '0;
        if (!enable) begin
            state_d = PH_EVEN;
        end else begin
            case (state_q)
                PH_EVEN: begin
                    if (s_valid) begin
                        low_d   = s_data;
                        state_d = PH_ODD;
                    end
                end
                PH_ODD: begin
                    if (s_valid) begin
                        push_req  = 1'b1;
                        push_word = {s_data, low_q};
                        state_d   = PH_EVEN;
                    end else if (flush) begin
                        // Pad the missing odd sample with zero.
                        push_req  = 1'b1;
                        push_word = {{SAMPLE_WIDTH{1'b0}}, low_q};
                        state_d   = PH_EVEN;
                    end
                end
                default: state_d = PH_EVEN;
            endcase
        end
    end

    // A full FIFO still takes a word when its head leaves in the same cycle.
    assign full    = (count == FILL_W'(FIFO_DEPTH));
    assign pop     = (count != '0) && m_ready;
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && !push_ok;

    // FIFO storage; write-only array, the head is read combinationally.
    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + FILL_W'(1);
                2'b01:   count <= count - FILL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Pushed-word counter, wraps modulo 2^COUNT_WIDTH.
    always_ff @(posedge aclk) begin
        if (areset) begin
            word_count <= '0;
        end else if (push_ok) begin
            word_count <= word_count + COUNT_WIDTH'(1);
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clear) begin
            ovf <= 1'b0;
        end
    end

`ifdef PACKER_OVF_COUNT_EN
    // Saturating drop counter; a clear with a concurrent drop leaves one.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ovf_count <= '0;
        end else if (drop && ovf_clear) begin
            ovf_count <= COUNT_WIDTH'(1);
        end else if (drop) begin
            if (ovf_count != '1) begin
                ovf_count <= ovf_count + COUNT_WIDTH'(1);
            end
        end else if (ovf_clear) begin
            ovf_count <= '0;
        end
    end
`endif

    assign m_valid    = (count != '0);
    assign m_data     = m_valid ? mem[rd_ptr] : '0;
    assign fill_level = count;
    assign phase_odd  = (state_q == PH_ODD);

endmodule

// File: tb/tb_wave_sample_packer.sv
// Directed testbench for wave_sample_packer: hand-computed expected words
// and counters checked with immediate assertions after each clock edge.
module tb_wave_sample_packer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        enable;
    logic        s_valid;
    logic [15:0] s_data;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [2:0]  fill_level;
    logic        phase_odd;
    logic        ovf;
    logic        ovf_clear;
    logic [31:0] word_count;
`ifdef PACKER_OVF_COUNT_EN
    logic [31:0] ovf_count;
`endif

    int checks   = 0;
    int failures = 0;

    wave_sample_packer #(
        .SAMPLE_WIDTH(16),
        .FIFO_DEPTH  (4),
        .COUNT_WIDTH (32)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .enable    (enable),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .fill_level(fill_level),
        .phase_odd (phase_odd),
        .ovf       (ovf),
        .ovf_clear (ovf_clear),
`ifdef PACKER_OVF_COUNT_EN
        .ovf_count (ovf_count),
`endif
        .word_count(word_count)
    );

    // Clock: 10 ns period.
    always #5 aclk = ~aclk;

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sample on one cycle.
    task automatic send(input logic [15:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic send_pair(input logic [15:0] lo, input logic [15:0] hi);
        send(lo);
        send(hi);
    endtask

    // Pop one word, checking it is the expected head first.
    task automatic pop_expect(input string tag, input logic [31:0] w);
        check({tag, "_valid"}, m_valid, 1'b1);
        check({tag, "_data"}, m_data, w);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        areset    = 1'b1;
        enable    = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        flush     = 1'b0;
        m_ready   = 1'b0;
        ovf_clear = 1'b0;
        tick();
        tick();
        areset = 1'b0;

        // Reset state.
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_fill", fill_level, 3'd0);
        check("rst_phase", phase_odd, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_wc", word_count, 32'd0);
`ifdef PACKER_OVF_COUNT_EN
        check("rst_ovfc", ovf_count, 32'd0);
`endif

        // 1: basic pair, consumer ready.
        m_ready = 1'b1;
        send(16'h1111);
        check("t1_phase_odd", phase_odd, 1'b1);
        check("t1_no_word", m_valid, 1'b0);
        send(16'h2222);
        check("t1_valid", m_valid, 1'b1);
        check("t1_data", m_data, 32'h22221111);
        check("t1_wc", word_count, 32'd1);
        check("t1_phase_even", phase_odd, 1'b0);
        tick();
        check("t1_drained", m_valid, 1'b0);
        check("t1_fill0", fill_level, 3'd0);
        m_ready = 1'b0;

        // 2: fill with backpressure, fifth pair dropped.
        for (int i = 0; i < 4; i++) send_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        check("t2_fill4", fill_level, 3'd4);
        check("t2_no_ovf", ovf, 1'b0);
        check("t2_wc5", word_count, 32'd5);
        send_pair(16'h1004, 16'h2004);
        check("t2_fill_still4", fill_level, 3'd4);
        check("t2_ovf", ovf, 1'b1);
        check("t2_wc_unchanged", word_count, 32'd5);
        check("t2_phase_even", phase_odd, 1'b0);
`ifdef PACKER_OVF_COUNT_EN
        check("t2_ovfc", ovf_count, 32'd1);
`endif
        pop_expect("t2_w0", 32'h20001000);
        pop_expect("t2_w1", 32'h20011001);
        pop_expect("t2_w2", 32'h20021002);
        pop_expect("t2_w3", 32'h20031003);
        check("t2_empty", fill_level, 3'd0);
        send_pair(16'h3000, 16'h3001);
        check("t2_aligned", m_data, 32'h30013000);
        tick();
        check("t2_stable", m_data, 32'h30013000);
        pop_expect("t2_w6", 32'h30013000);
        check("t2_wc6", word_count, 32'd6);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("t2_ovf_cleared", ovf, 1'b0);
`ifdef PACKER_OVF_COUNT_EN
        check("t2_ovfc_cleared", ovf_count, 32'd0);
`endif

        // 3: full FIFO, odd sample coincides with a pop.
        for (int i = 0; i < 4; i++) send_pair(16'h4000 + 16'(i), 16'h5000 + 16'(i));
        check("t3_fill4", fill_level, 3'd4);
        send(16'h6000);
        m_ready = 1'b1;
        send(16'h6001);
        m_ready = 1'b0;
        check("t3_fill_kept", fill_level, 3'd4);
        check("t3_no_ovf", ovf, 1'b0);
        check("t3_wc11", word_count, 32'd11);
        pop_expect("t3_w1", 32'h50014001);
        pop_expect("t3_w2", 32'h50024002);
        pop_expect("t3_w3", 32'h50034003);
        pop_expect("t3_w4", 32'h60016000);
        check("t3_empty", m_valid, 1'b0);

        // 4: flush behaviour.
        send(16'hABCD);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_fill1", fill_level, 3'd1);
        check("t4_phase", phase_odd, 1'b0);
        check("t4_wc12", word_count, 32'd12);
        pop_expect("t4_padded", 32'h0000ABCD);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_even_noop", fill_level, 3'd0);
        check("t4_even_wc", word_count, 32'd12);
        send(16'h4444);
        flush = 1'b1;
        send(16'h5555);
        flush = 1'b0;
        tick();
        check("t4_single_word", fill_level, 3'd1);
        check("t4_wc13", word_count, 32'd13);
        pop_expect("t4_pair", 32'h55554444);

        // 5a: reset mid-word discards the pending half.
        send(16'h7777);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("t5_rst_phase", phase_odd, 1'b0);
        check("t5_rst_wc", word_count, 32'd0);
        send_pair(16'h0001, 16'h0002);
        check("t5_rst_wc1", word_count, 32'd1);
        pop_expect("t5_rst_word", 32'h00020001);

        // 5b: enable low mid-word discards the pending half.
        send(16'h7777);
        enable = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h9999;
        tick();
        s_valid = 1'b0;
        enable  = 1'b1;
        check("t5_en_phase", phase_odd, 1'b0);
        check("t5_en_no_word", fill_level, 3'd0);
        send_pair(16'h0001, 16'h0002);
        pop_expect("t5_en_word", 32'h00020001);
        check("t5_en_wc2", word_count, 32'd2);

        // 5c: clear concurrent with a drop leaves ovf set.
        for (int i = 0; i < 4; i++) send_pair(16'h8000 + 16'(i), 16'h8100 + 16'(i));
        send_pair(16'h8004, 16'h8104);
        check("t5_ovf_set", ovf, 1'b1);
        send(16'h8005);
        ovf_clear = 1'b1;
        send(16'h8105);
        ovf_clear = 1'b0;
        check("t5_set_wins", ovf, 1'b1);
        check("t5_wc6", word_count, 32'd6);
`ifdef PACKER_OVF_COUNT_EN
        check("t5_ovfc_one", ovf_count, 32'd1);
`endif
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("t5_ovf_clear", ovf, 1'b0);
        pop_expect("t5_d0", 32'h81008000);
        pop_expect("t5_d1", 32'h81018001);
        pop_expect("t5_d2", 32'h81028002);
        pop_expect("t5_d3", 32'h81038003);

        // m_ready on an empty FIFO is ignored.
        m_ready = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        check("empty_pop_fill", fill_level, 3'd0);
        check("empty_pop_valid", m_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
